// File: rtl/gpio_bus_arbiter.sv
// Round-robin share of one GPIO slave port among NUM_M masters; strobe, wait for ready or timeout, ack.
// Latency: grant edge to ack edge is 2 cycles with an immediate ready; 4 cycles per transaction; requests held off until IDLE.
module gpio_bus_arbiter #(
   parameter int NUM_M   = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15,
   localparam int GID_W  = (NUM_M > 1) ? $clog2(NUM_M) : 1,
   localparam int TMR_W  = $clog2(TIMEOUT) + 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_M-1:0]         m_req,
   input  logic [NUM_M-1:0]         m_rw,
   input  logic [NUM_M*ADDR_W-1:0]  m_addr,
   input  logic [NUM_M*DATA_W-1:0]  m_wr_data,
   output logic [NUM_M-1:0]         m_ack,
   output logic                     m_err,
   output logic [DATA_W-1:0]        m_rd_data,
   output logic [GID_W-1:0]         grant_id,
   output logic                     busy,
   output logic                     s_cs_,
   output logic                     s_as_,
   output logic                     s_rw,
   output logic [ADDR_W-1:0]        s_addr,
   output logic [DATA_W-1:0]        s_wr_data,
   input  logic [DATA_W-1:0]        s_rd_data,
   input  logic                     s_rdy_
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STROBE = 2'd1;
   localparam logic [1:0] ST_WAIT   = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   localparam logic [NUM_M-1:0] ACK_ONE = {{(NUM_M-1){1'b0}}, 1'b1};

   logic [1:0]        state;
   logic [TMR_W-1:0]  timer;
   logic [GID_W-1:0]  win;
   logic [GID_W-1:0]  cand;
   logic              found;
   logic              sel_rw;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   // grant_id doubles as the round-robin pointer: search starts just past the last winner
   always_comb begin
      win   = grant_id;
      found = 1'b0;
      cand  = '0;
      for (int i = 1; i <= NUM_M; i++) begin
         cand = GID_W'((int'(grant_id) + i) % NUM_M);
         if (!found && m_req[cand]) begin
            found = 1'b1;
            win   = cand;
         end
      end
   end

   always_comb begin
      sel_rw    = 1'b0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_M; i++) begin
         if (win == GID_W'(i)) begin
            sel_rw    = m_rw[i];
            sel_addr  = m_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = m_wr_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         timer     <= '0;
         grant_id  <= GID_W'(NUM_M - 1);
         busy      <= 1'b0;
         s_cs_     <= 1'b1;
         s_as_     <= 1'b1;
         s_rw      <= 1'b1;
         s_addr    <= '0;
         s_wr_data <= '0;
         m_ack     <= '0;
         m_err     <= 1'b0;
         m_rd_data <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (found) begin
                  grant_id  <= win;
                  s_rw      <= sel_rw;
                  s_addr    <= sel_addr;
                  s_wr_data <= sel_wdata;
                  s_cs_     <= 1'b0;
                  s_as_     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= ST_STROBE;
               end
            end
            ST_STROBE: begin
               s_cs_ <= 1'b1;
               s_as_ <= 1'b1;
               timer <= '0;
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (!s_rdy_) begin
                  m_rd_data <= s_rw ? s_rd_data : '0;
                  m_ack     <= ACK_ONE << grant_id;
                  m_err     <= 1'b0;
                  state     <= ST_DONE;
               end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                  m_rd_data <= '0;
                  m_ack     <= ACK_ONE << grant_id;
                  m_err     <= 1'b1;
                  state     <= ST_DONE;
               end else begin
                  timer <= timer + 1'b1;
               end
            end
            default: begin
               m_ack <= '0;
               m_err <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpio_bus_arbiter.sv
// Directed bench for gpio_bus_arbiter with a one-cycle-ready slave model that can be switched off for timeouts.
module tb_gpio_bus_arbiter;

   localparam int NUM_M = 4;
   localparam int ADDR_W = 2;
   localparam int DATA_W = 32;

   logic                    clk = 1'b0;
   logic                    rst_n = 1'b1;
   logic [NUM_M-1:0]        m_req = '0;
   logic [NUM_M-1:0]        m_rw = '0;
   logic [NUM_M*ADDR_W-1:0] m_addr = '0;
   logic [NUM_M*DATA_W-1:0] m_wr_data = '0;
   logic [NUM_M-1:0]        m_ack;
   logic                    m_err;
   logic [DATA_W-1:0]       m_rd_data;
   logic [1:0]              grant_id;
   logic                    busy;
   logic                    s_cs_;
   logic                    s_as_;
   logic                    s_rw;
   logic [ADDR_W-1:0]       s_addr;
   logic [DATA_W-1:0]       s_wr_data;
   logic [DATA_W-1:0]       s_rd_data = '0;
   logic                    s_rdy_;

   logic strobe_seen = 1'b0;
   logic slave_on = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   n;
   int   st;

   gpio_bus_arbiter #(.NUM_M(NUM_M), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(15)) dut (
      .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_rw(m_rw), .m_addr(m_addr),
      .m_wr_data(m_wr_data), .m_ack(m_ack), .m_err(m_err), .m_rd_data(m_rd_data),
      .grant_id(grant_id), .busy(busy), .s_cs_(s_cs_), .s_as_(s_as_), .s_rw(s_rw),
      .s_addr(s_addr), .s_wr_data(s_wr_data), .s_rd_data(s_rd_data), .s_rdy_(s_rdy_)
   );

   always #5 clk = ~clk;

   // slave answers ready in the cycle right after the strobe
   always @(posedge clk) strobe_seen <= !s_as_ && rst_n;
   assign s_rdy_ = !(strobe_seen && slave_on);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // returns cycles until an ack appears and how many strobes were seen meanwhile
   task automatic wait_ack(output int cyc, output int strobes);
      cyc = 0;
      strobes = 0;
      do begin
         tick();
         cyc++;
         if (!s_as_) strobes++;
      end while (m_ack == '0 && cyc < 40);
      check_eq("ack_seen", {31'd0, m_ack != '0}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0;
      tick();
      tick();
      check_eq("rst_cs", {31'd0, s_cs_}, 32'd1);
      check_eq("rst_as", {31'd0, s_as_}, 32'd1);
      check_eq("rst_rw", {31'd0, s_rw}, 32'd1);
      check_eq("rst_addr", {30'd0, s_addr}, 32'd0);
      check_eq("rst_wdata", s_wr_data, 32'd0);
      check_eq("rst_ack", {28'd0, m_ack}, 32'd0);
      check_eq("rst_gid", {30'd0, grant_id}, 32'd3);
      check_eq("rst_busy", {31'd0, busy}, 32'd0);

      // single write from master 0
      m_req = 4'b0001;
      m_addr[0 +: ADDR_W] = 2'd1;
      m_wr_data[0 +: DATA_W] = 32'h0000_00A5;
      @(negedge clk) rst_n = 1'b1;
      tick();
      check_eq("w_cs", {31'd0, s_cs_}, 32'd0);
      check_eq("w_as", {31'd0, s_as_}, 32'd0);
      check_eq("w_addr", {30'd0, s_addr}, 32'd1);
      check_eq("w_rw", {31'd0, s_rw}, 32'd0);
      check_eq("w_wdata", s_wr_data, 32'hA5);
      check_eq("w_busy", {31'd0, busy}, 32'd1);
      m_req = '0;
      wait_ack(n, st);
      check_eq("w_lat", n, 2);
      check_eq("w_ack", {28'd0, m_ack}, 32'b0001);
      check_eq("w_err", {31'd0, m_err}, 32'd0);
      tick();
      check_eq("w_ack_clr", {28'd0, m_ack}, 32'd0);
      check_eq("w_idle", {31'd0, busy}, 32'd0);

      // read from master 2
      m_req = 4'b0100;
      m_rw = 4'b0100;
      m_addr[2*ADDR_W +: ADDR_W] = 2'd0;
      s_rd_data = 32'h0000_00F3;
      tick();
      check_eq("r_gid", {30'd0, grant_id}, 32'd2);
      check_eq("r_rw", {31'd0, s_rw}, 32'd1);
      check_eq("r_addr", {30'd0, s_addr}, 32'd0);
      m_req = '0;
      wait_ack(n, st);
      check_eq("r_lat", n, 2);
      check_eq("r_ack", {28'd0, m_ack}, 32'b0100);
      check_eq("r_data", m_rd_data, 32'hF3);
      tick();

      // all four requesting after a fresh reset
      rst_n = 1'b0;
      tick();
      m_req = 4'b1111;
      m_rw = '0;
      @(negedge clk) rst_n = 1'b1;
      for (int k = 0; k < 5; k++) begin
         wait_ack(n, st);
         check_eq("rr_ack", {28'd0, m_ack}, 32'd1 << (k % 4));
         check_eq("rr_gid", {30'd0, grant_id}, k % 4);
         check_eq("rr_gap", n, (k == 0) ? 3 : 4);
         check_eq("rr_wr_rd", m_rd_data, 32'd0);
      end
      m_req = '0;
      tick();

      // master 1 served, then 3 and 1 together: 3 must win
      m_req = 4'b0010;
      m_rw = 4'b0010;
      s_rd_data = 32'h0000_005A;
      wait_ack(n, st);
      check_eq("p_ack1", {28'd0, m_ack}, 32'b0010);
      check_eq("p_rd1", m_rd_data, 32'h5A);
      m_req = '0;
      tick();
      m_req = 4'b1010;
      wait_ack(n, st);
      check_eq("p_ack3", {28'd0, m_ack}, 32'b1000);
      check_eq("p_rd3", m_rd_data, 32'd0);
      m_req = 4'b0010;
      wait_ack(n, st);
      check_eq("p_ack1b", {28'd0, m_ack}, 32'b0010);
      check_eq("p_gap", n, 4);
      check_eq("p_rd1b", m_rd_data, 32'h5A);
      m_req = '0;
      tick();

      // slave never ready: error after the full wait window, single strobe
      slave_on = 1'b0;
      m_req = 4'b0001;
      m_rw = 4'b0001;
      tick();
      check_eq("t_gid", {30'd0, grant_id}, 32'd0);
      check_eq("t_as", {31'd0, s_as_}, 32'd0);
      m_req = '0;
      wait_ack(n, st);
      check_eq("t_lat", n, 16);
      check_eq("t_ack", {28'd0, m_ack}, 32'b0001);
      check_eq("t_err", {31'd0, m_err}, 32'd1);
      check_eq("t_rd", m_rd_data, 32'd0);
      check_eq("t_no_restrobe", st, 0);
      tick();
      check_eq("t_err_clr", {31'd0, m_err}, 32'd0);
      tick();
      tick();
      check_eq("t_quiet_as", {31'd0, s_as_}, 32'd1);
      check_eq("t_quiet_busy", {31'd0, busy}, 32'd0);

      // reset in WAIT aborts without ack and restarts the pointer
      m_req = 4'b0100;
      tick();
      check_eq("a_gid", {30'd0, grant_id}, 32'd2);
      m_req = 4'b1001;
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      check_eq("a_cs", {31'd0, s_cs_}, 32'd1);
      check_eq("a_as", {31'd0, s_as_}, 32'd1);
      check_eq("a_ack", {28'd0, m_ack}, 32'd0);
      check_eq("a_busy", {31'd0, busy}, 32'd0);
      check_eq("a_gid_rst", {30'd0, grant_id}, 32'd3);
      @(negedge clk);
      slave_on = 1'b1;
      rst_n = 1'b1;
      wait_ack(n, st);
      check_eq("a_first", {28'd0, m_ack}, 32'b0001);
      check_eq("a_lat", n, 3);
      m_req = 4'b1000;
      wait_ack(n, st);
      check_eq("a_m3", {28'd0, m_ack}, 32'b1000);
      check_eq("a_m3_gid", {30'd0, grant_id}, 32'd3);
      m_req = '0;
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
